// File: rtl/logfbe_fifo_wl.sv
// Single-clock FIFO for the logfbe path: distributed RAM, standard or FWFT read,
// registered water level and almost flags, sticky overflow/underflow, synchronous flush.
module logfbe_fifo_wl #(
   parameter int unsigned ADDR_WIDTH       = 5,
   parameter int unsigned DATA_WIDTH       = 16,
   parameter bit          FWFT             = 1'b0,
   parameter int unsigned ALMOST_FULL_NUM  = 26,
   parameter int unsigned ALMOST_EMPTY_NUM = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  full,
   output logic                  almost_full,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  empty,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   water_level,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned LW    = ADDR_WIDTH + 1;

   // Reject parameter sets the pointer/level arithmetic cannot represent.
   if (ADDR_WIDTH < 2 || ADDR_WIDTH > 10) begin : g_bad_addr_width
      $error("logfbe_fifo_wl: ADDR_WIDTH must be 2..10");
   end
   if (DATA_WIDTH < 1 || DATA_WIDTH > 256) begin : g_bad_data_width
      $error("logfbe_fifo_wl: DATA_WIDTH must be 1..256");
   end
   if (ALMOST_FULL_NUM < 1 || ALMOST_FULL_NUM > DEPTH) begin : g_bad_af
      $error("logfbe_fifo_wl: ALMOST_FULL_NUM must be 1..DEPTH");
   end
   if (ALMOST_EMPTY_NUM > DEPTH - 1) begin : g_bad_ae
      $error("logfbe_fifo_wl: ALMOST_EMPTY_NUM must be 0..DEPTH-1");
   end

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]         level_q, level_d;
   logic                  full_q, full_d;
   logic                  empty_q, empty_d;
   logic                  afull_q, afull_d;
   logic                  aempty_q, aempty_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  wr_acc_c;
   logic                  rd_acc_c;

   // Next-state: accept on registered flags, derive all flags from the next level.
   always_comb begin
      wr_acc_c  = wr_en & ~full_q;
      rd_acc_c  = rd_en & ~empty_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      rd_data_d = rd_data_q;
      ovf_d     = ovf_q;
      udf_d     = udf_q;
      level_d   = level_q + LW'(wr_acc_c) - LW'(rd_acc_c);

      if (wr_acc_c) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (rd_acc_c) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      if (!FWFT && rd_acc_c) rd_data_d = mem_q[rd_ptr_q];
      if (wr_en && full_q) ovf_d = 1'b1;
      if (rd_en && empty_q) udf_d = 1'b1;

      full_d   = (level_d == LW'(DEPTH));
      empty_d  = (level_d == '0);
      afull_d  = (level_d >= LW'(ALMOST_FULL_NUM));
      aempty_d = (level_d <= LW'(ALMOST_EMPTY_NUM));

      // Flush wins over any same-cycle access.
      if (clr) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         level_d   = '0;
         rd_data_d = '0;
         ovf_d     = 1'b0;
         udf_d     = 1'b0;
         full_d    = 1'b0;
         empty_d   = 1'b1;
         afull_d   = 1'b0;
         aempty_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         afull_q   <= 1'b0;
         aempty_q  <= 1'b1;
         ovf_q     <= 1'b0;
         udf_q     <= 1'b0;
         rd_data_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         full_q    <= full_d;
         empty_q   <= empty_d;
         afull_q   <= afull_d;
         aempty_q  <= aempty_d;
         ovf_q     <= ovf_d;
         udf_q     <= udf_d;
         rd_data_q <= rd_data_d;
      end
   end

   // Storage is not reset; gated so a flush or reset cycle never commits a word.
   always_ff @(posedge clk) begin
      if (wr_acc_c && !clr && rst_n) mem_q[wr_ptr_q] <= wr_data;
   end

   // FWFT shows the head asynchronously; while empty the held (zero) register is shown.
   assign rd_data      = (FWFT && !empty_q) ? mem_q[rd_ptr_q] : rd_data_q;
   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = afull_q;
   assign almost_empty = aempty_q;
   assign water_level  = level_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

endmodule

// File: tb/tb_logfbe_fifo_wl.sv
// Directed bench for logfbe_fifo_wl: one standard-read and one FWFT instance, DEPTH=32.
module tb_logfbe_fifo_wl;

   logic        clk;
   logic        rst_n;

   logic        clr0, wr_en0, rd_en0;
   logic [15:0] wr_data0, rd_data0;
   logic        full0, afull0, empty0, aempty0, ovf0, udf0;
   logic [5:0]  level0;

   logic        clr1, wr_en1, rd_en1;
   logic [15:0] wr_data1, rd_data1;
   logic        full1, afull1, empty1, aempty1, ovf1, udf1;
   logic [5:0]  level1;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;
   logic [15:0] exp_q [$];
   logic [15:0] exp_word;

   logfbe_fifo_wl #(.ADDR_WIDTH(5), .DATA_WIDTH(16), .FWFT(1'b0),
                    .ALMOST_FULL_NUM(26), .ALMOST_EMPTY_NUM(4)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .clr(clr0), .wr_en(wr_en0), .wr_data(wr_data0),
      .full(full0), .almost_full(afull0), .rd_en(rd_en0), .rd_data(rd_data0),
      .empty(empty0), .almost_empty(aempty0), .water_level(level0),
      .overflow(ovf0), .underflow(udf0));

   logfbe_fifo_wl #(.ADDR_WIDTH(5), .DATA_WIDTH(16), .FWFT(1'b1),
                    .ALMOST_FULL_NUM(26), .ALMOST_EMPTY_NUM(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .clr(clr1), .wr_en(wr_en1), .wr_data(wr_data1),
      .full(full1), .almost_full(afull1), .rd_en(rd_en1), .rd_data(rd_data1),
      .empty(empty1), .almost_empty(aempty1), .water_level(level1),
      .overflow(ovf1), .underflow(udf1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      clr0 = 0; wr_en0 = 0; rd_en0 = 0; wr_data0 = '0;
      clr1 = 0; wr_en1 = 0; rd_en1 = 0; wr_data1 = '0;
      #12;
      chk("rst_level", 32'(level0), 0);
      chk("rst_empty", 32'(empty0), 1);
      chk("rst_aempty", 32'(aempty0), 1);
      chk("rst_full", 32'(full0), 0);
      chk("rst_afull", 32'(afull0), 0);
      chk("rst_rdata", 32'(rd_data0), 0);
      chk("rst_ovf", 32'(ovf0), 0);
      chk("rst_udf", 32'(udf0), 0);
      chk("rst_rdata_fwft", 32'(rd_data1), 0);
      rst_n = 1'b1;
      tick();

      // 1: fill 32 words, then one rejected write
      for (int i = 1; i <= 32; i++) begin
         wr_en0 = 1; wr_data0 = 16'(i);
         tick();
         chk("fill_level", 32'(level0), 32'(i));
         chk("fill_afull", 32'(afull0), (i >= 26) ? 1 : 0);
         chk("fill_full", 32'(full0), (i == 32) ? 1 : 0);
      end
      wr_data0 = 16'h0099;
      tick();
      wr_en0 = 0;
      chk("ovf_set", 32'(ovf0), 1);
      chk("ovf_level", 32'(level0), 32);

      // 2: drain 32 words in order, then one rejected read
      for (int i = 1; i <= 32; i++) begin
         rd_en0 = 1;
         tick();
         chk("drain_data", 32'(rd_data0), 32'(i));
         chk("drain_level", 32'(level0), 32'(32 - i));
         chk("drain_aempty", 32'(aempty0), (32 - i <= 4) ? 1 : 0);
         chk("drain_empty", 32'(empty0), (i == 32) ? 1 : 0);
      end
      tick();
      rd_en0 = 0;
      chk("udf_set", 32'(udf0), 1);
      chk("udf_hold_data", 32'(rd_data0), 32'h20);
      chk("ovf_sticky", 32'(ovf0), 1);

      // 3: level 10, 50 cycles of simultaneous read+write across pointer wrap
      for (int i = 0; i < 10; i++) begin
         wr_en0 = 1; wr_data0 = 16'h0100 + 16'(i);
         exp_q.push_back(wr_data0);
         tick();
      end
      wr_en0 = 0;
      chk("lvl10", 32'(level0), 10);
      for (int c = 0; c < 50; c++) begin
         wr_en0 = 1; rd_en0 = 1; wr_data0 = 16'h0200 + 16'(c);
         exp_q.push_back(wr_data0);
         exp_word = exp_q.pop_front();
         tick();
         chk("stream_data", 32'(rd_data0), 32'(exp_word));
         chk("stream_level", 32'(level0), 10);
      end
      wr_en0 = 0; rd_en0 = 0;
      exp_q.delete();

      // 4: flush, refill to full, then simultaneous read+write while full
      clr0 = 1;
      tick();
      clr0 = 0;
      chk("clr_ovf", 32'(ovf0), 0);
      chk("clr_udf", 32'(udf0), 0);
      for (int i = 0; i < 32; i++) begin
         wr_en0 = 1; wr_data0 = 16'h0400 + 16'(i);
         tick();
      end
      chk("refill_full", 32'(full0), 1);
      wr_en0 = 1; rd_en0 = 1; wr_data0 = 16'hDEAD;
      tick();
      wr_en0 = 0; rd_en0 = 0;
      chk("fullrw_data", 32'(rd_data0), 32'h0400);
      chk("fullrw_level", 32'(level0), 31);
      chk("fullrw_ovf", 32'(ovf0), 1);
      chk("fullrw_full", 32'(full0), 0);
      rd_en0 = 1;
      for (int i = 1; i < 31; i++) tick();
      tick();
      rd_en0 = 0;
      chk("fullrw_last", 32'(rd_data0), 32'h041F);
      chk("fullrw_empty", 32'(empty0), 1);

      // 5: FWFT instance
      wr_en1 = 1; wr_data1 = 16'hABCD;
      tick();
      wr_en1 = 0;
      chk("fwft_empty0", 32'(empty1), 0);
      chk("fwft_data", 32'(rd_data1), 32'hABCD);
      tick();
      chk("fwft_hold", 32'(rd_data1), 32'hABCD);
      rd_en1 = 1;
      tick();
      rd_en1 = 0;
      chk("fwft_empty1", 32'(empty1), 1);
      chk("fwft_level0", 32'(level1), 0);
      wr_en1 = 1; wr_data1 = 16'h1111;
      tick();
      chk("fwft_w1", 32'(rd_data1), 32'h1111);
      rd_en1 = 1; wr_data1 = 16'h2222;
      tick();
      wr_en1 = 0; rd_en1 = 0;
      chk("fwft_rw_data", 32'(rd_data1), 32'h2222);
      chk("fwft_rw_level", 32'(level1), 1);

      // 6: flush with a concurrent write, then async reset mid-burst
      clr0 = 1;
      tick();
      clr0 = 0;
      for (int i = 0; i < 20; i++) begin
         wr_en0 = 1; wr_data0 = 16'h0500 + 16'(i);
         tick();
      end
      chk("pre_clr_level", 32'(level0), 20);
      clr0 = 1; wr_data0 = 16'h0BAD;
      tick();
      clr0 = 0;
      chk("clrw_level", 32'(level0), 0);
      chk("clrw_empty", 32'(empty0), 1);
      chk("clrw_aempty", 32'(aempty0), 1);
      chk("clrw_ovf", 32'(ovf0), 0);
      chk("clrw_udf", 32'(udf0), 0);
      chk("clrw_rdata", 32'(rd_data0), 0);
      for (int i = 0; i < 5; i++) begin
         wr_data0 = 16'h0600 + 16'(i);
         tick();
      end
      chk("burst_level", 32'(level0), 5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_level", 32'(level0), 0);
      chk("arst_empty", 32'(empty0), 1);
      chk("arst_afull", 32'(afull0), 0);
      chk("arst_rdata", 32'(rd_data0), 0);
      wr_en0 = 0;
      #3;
      rst_n = 1'b1;
      tick();
      tick();
      chk("post_arst_level", 32'(level0), 0);
      chk("post_arst_empty", 32'(empty0), 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
